dot_channel_seq: RTL and testbench
==================================

Name: dot_channel_seq

Overview:
- Sequencer for one dot channel. It steps through every (cs, phase) weight slice and drives the channel's dc_load, ws_load, cs and phase.
- Waits for the channel's valid, captures its scalar result, and presents it downstream on a valid/ready handshake tagged with the slice index.
- Sits between the layer-level scheduler (start/done) and the dot channel plus its feature-vector source.

Parameters:
- CS_NUM, 9, number of channel-select values walked (1..16).
- PHASE_NUM, 8, phases per cs value (1..8).
- TIMEOUT, 31, max cycles in LOAD without dc_valid before error (>= 8).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a full sweep; ignored unless IDLE, DONE or ERR
- in_avail  in  1  feature vector d for the current (cs, phase) is valid at the dot channel
- in_ack  out  1  one-cycle pulse; current feature vector consumed
- dc_valid  in  1  dot channel valid
- dc_q  in  `data_len  dot channel result
- dc_load  out  1  to dot channel dc_load
- ws_load  out  1  to dot channel ws_load
- cs  out  4  slice select to dot channel
- phase  out  3  phase to dot channel
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts result
- out_data  out  `data_len  captured result
- out_cs  out  4  cs tag of out_data
- out_phase  out  3  phase tag of out_data
- busy  out  1  high in any state other than IDLE, DONE, ERR
- done  out  1  sticky; full sweep completed; cleared by start
- err  out  1  sticky; timeout occurred; cleared by start

Behaviour:
- Reset (async, any state): state=IDLE. All outputs 0, including cs/phase/tags. Internal counters 0.
- States: IDLE, WAIT_IN, LOAD, OUT, GAP, DONE, ERR.
- IDLE/DONE/ERR + start: clear done/err, cs=0, phase=0, go to WAIT_IN.
- WAIT_IN: loads low. When in_avail=1, go to LOAD next cycle.
- LOAD:
  - dc_load=ws_load=1; cs/phase held stable; wait counter increments each cycle.
  - First cycle with dc_valid=1: register dc_q into out_data, cs/phase into the tags. Set out_valid=1, pulse in_ack, drop both loads, go to OUT.
  - If the counter reaches TIMEOUT with no dc_valid: drop loads, set err, go to ERR. No in_ack and no out_valid.
- OUT:
  - out_valid holds until out_ready=1 is sampled; out_data and tags are stable while held.
  - On acceptance, out_valid=0 and go to GAP.
  - If out_ready=1 in the first OUT cycle, the transfer completes in that cycle (no extra bubble).
- GAP: exactly one cycle with loads low, guaranteeing the dot channel clears its inner counter and valid. Then advance the index:
  - phase+1.
  - If phase==PHASE_NUM-1: phase=0, cs+1.
  - If cs==CS_NUM-1 and phase==PHASE_NUM-1: set done, go to DONE (cs/phase hold last value). Otherwise go to WAIT_IN.
- Order: phase is the inner loop, cs the outer loop. Results leave strictly in index order, one per slice; total CS_NUM*PHASE_NUM.
- A dc_valid seen outside LOAD is ignored.
- start while busy is ignored.
- With a nominal dot channel and in_avail, out_ready tied high, the per-slice period is a fixed count. The bench measures it once and checks it is constant.
- Wait counter width: clog2(TIMEOUT+1). It resets on every entry to LOAD.

Decomposition:
- Shared header num_data.v supplies `data_len.
- State encodings and the CS_W=4 / PH_W=3 widths go in a shared include, dot_seq_defs.v.
- One natural sub-module: seq_index_counter. It holds the nested cs/phase counter with advance input and last output.
- The FSM, wait counter and output register stay in the top.

Test Plan:
- Reset mid-LOAD (cs=2, phase=5): rst high for 1 cycle -> dc_load, ws_load, out_valid, busy all 0 immediately; cs=0, phase=0.
- Full sweep, CS_NUM=2, PHASE_NUM=3, in_avail=1, out_ready=1, channel model returns q={cs,phase} -> 6 results in order (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); done=1 after last; 6 in_ack pulses.
- Backpressure: out_ready low for 10 cycles on slice (0,1) -> out_valid held with out_data stable; dc_load stays 0; no index advance until acceptance.
- in_avail low for 5 cycles before slice (1,0) -> no dc_load during the gap; result still correct.
- Channel never asserts valid, TIMEOUT=31 -> loads drop after 31 LOAD cycles; err=1; no out_valid. A subsequent start clears err and restarts at (0,0).
- start pulsed while busy at slice (0,2) -> ignored; sweep completes normally with 6 results.

Source files
------------

// File: rtl/dot_channel_seq_pkg.sv
// Shared widths, data length and FSM state encoding for the dot channel sequencer.
package dot_channel_seq_pkg;
    localparam int DATA_LEN = 16;
    localparam int CS_W     = 4;
    localparam int PH_W     = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_IN = 3'd1,
        ST_LOAD    = 3'd2,
        ST_OUT     = 3'd3,
        ST_GAP     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;
endpackage

// File: rtl/dot_channel_seq_index_counter.sv
// Nested (cs, phase) slice index, phase innermost; saturates on the last slice.
// Single-cycle update on clear/advance; no backpressure of its own.
module dot_channel_seq_index_counter
    import dot_channel_seq_pkg::*;
#(
    parameter int CS_NUM    = 9,
    parameter int PHASE_NUM = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear_i,
    input  logic            advance_i,
    output logic [CS_W-1:0] cs_o,
    output logic [PH_W-1:0] phase_o,
    output logic            last_o
);
    localparam logic [CS_W-1:0] CS_LAST = CS_W'(CS_NUM - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASE_NUM - 1);

    logic [CS_W-1:0] cs_q, cs_d;
    logic [PH_W-1:0] ph_q, ph_d;
    logic            ph_wrap;

    assign ph_wrap = (ph_q == PH_LAST);
    assign last_o  = ph_wrap && (cs_q == CS_LAST);
    assign cs_o    = cs_q;
    assign phase_o = ph_q;

    always_comb begin
        cs_d = cs_q;
        ph_d = ph_q;
        if (clear_i) begin
            cs_d = '0;
            ph_d = '0;
        end else if (advance_i && !last_o) begin
            if (ph_wrap) begin
                ph_d = '0;
                cs_d = cs_q + 1'b1;
            end else begin
                ph_d = ph_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_q <= '0;
            ph_q <= '0;
        end else begin
            cs_q <= cs_d;
            ph_q <= ph_d;
        end
    end
endmodule

// File: rtl/dot_channel_seq.sv
// Walks every (cs, phase) slice through one dot channel and hands each result downstream.
// Per slice: 1 WAIT_IN + LOAD until dc_valid + OUT until out_ready + 1 GAP; out_valid holds under backpressure.
module dot_channel_seq
    import dot_channel_seq_pkg::*;
#(
    parameter int CS_NUM    = 9,
    parameter int PHASE_NUM = 8,
    parameter int TIMEOUT   = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                in_avail,
    output logic                in_ack,
    input  logic                dc_valid,
    input  logic [DATA_LEN-1:0] dc_q,
    output logic                dc_load,
    output logic                ws_load,
    output logic [CS_W-1:0]     cs,
    output logic [PH_W-1:0]     phase,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] out_data,
    output logic [CS_W-1:0]     out_cs,
    output logic [PH_W-1:0]     out_phase,
    output logic                busy,
    output logic                done,
    output logic                err
);
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ack_q, in_ack_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [DATA_LEN-1:0] data_q, data_d;
    logic [CS_W-1:0]     tag_cs_q, tag_cs_d;
    logic [PH_W-1:0]     tag_ph_q, tag_ph_d;
    logic                idx_clear, idx_advance, idx_last;

    dot_channel_seq_index_counter #(
        .CS_NUM    (CS_NUM),
        .PHASE_NUM (PHASE_NUM)
    ) u_index (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (idx_clear),
        .advance_i (idx_advance),
        .cs_o      (cs),
        .phase_o   (phase),
        .last_o    (idx_last)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        in_ack_d    = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        data_d      = data_q;
        tag_cs_d    = tag_cs_q;
        tag_ph_d    = tag_ph_q;
        idx_clear   = 1'b0;
        idx_advance = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    idx_clear = 1'b1;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    state_d   = ST_WAIT_IN;
                end
            end
            ST_WAIT_IN: begin
                if (in_avail) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // cnt_q counts LOAD cycles already spent without a result.
                if (dc_valid) begin
                    data_d      = dc_q;
                    tag_cs_d    = cs;
                    tag_ph_d    = phase;
                    out_valid_d = 1'b1;
                    in_ack_d    = 1'b1;
                    state_d     = ST_OUT;
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERR;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_GAP;
                end
            end
            ST_GAP: begin
                if (idx_last) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    idx_advance = 1'b1;
                    state_d     = ST_WAIT_IN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ack_q    <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            data_q      <= '0;
            tag_cs_q    <= '0;
            tag_ph_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            in_ack_q    <= in_ack_d;
            done_q      <= done_d;
            err_q       <= err_d;
            data_q      <= data_d;
            tag_cs_q    <= tag_cs_d;
            tag_ph_q    <= tag_ph_d;
        end
    end

    assign dc_load   = (state_q == ST_LOAD);
    assign ws_load   = (state_q == ST_LOAD);
    assign busy      = !((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign out_valid = out_valid_q;
    assign in_ack    = in_ack_q;
    assign done      = done_q;
    assign err       = err_q;
    assign out_data  = data_q;
    assign out_cs    = tag_cs_q;
    assign out_phase = tag_ph_q;
endmodule

// File: tb/tb_dot_channel_seq.sv
// Randomized bench for dot_channel_seq with a behavioural dot channel and an index-order reference model.
module tb_dot_channel_seq;
    localparam int CS_N = 2;
    localparam int PH_N = 3;
    localparam int TO   = 31;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_avail = 1'b1;
    logic        in_ack;
    logic        dc_valid;
    logic [15:0] dc_q;
    logic        dc_load, ws_load;
    logic [3:0]  cs, out_cs;
    logic [2:0]  phase, out_phase;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic        busy, done, err;

    int          n_checks = 0;
    int          n_pass = 0;

    // behavioural dot channel: valid after ch_lat+1 load cycles, q = {salt, cs, phase}
    int          ch_lat = 2;
    bit          ch_dead = 1'b0;
    bit          noise = 1'b0;
    int          ch_cnt;
    logic [8:0]  salt = '0;

    logic [22:0] exp_q[$];
    logic [22:0] got_q[$];
    int          periods[$];
    int          n_ack, viol, bp_seen, starve_seen, load_cycles, ov_cnt;
    bit          start_fired;
    logic        done_after_start, err_after_start;

    dot_channel_seq #(.CS_NUM(CS_N), .PHASE_NUM(PH_N), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_avail  (in_avail),
        .in_ack    (in_ack),
        .dc_valid  (dc_valid),
        .dc_q      (dc_q),
        .dc_load   (dc_load),
        .ws_load   (ws_load),
        .cs        (cs),
        .phase     (phase),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_cs    (out_cs),
        .out_phase (out_phase),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) ch_cnt <= 0;
        else if (!dc_load) ch_cnt <= 0;
        else ch_cnt <= ch_cnt + 1;
    end
    assign dc_valid = dc_load ? (!ch_dead && ch_cnt == ch_lat) : noise;
    assign dc_q     = {salt, cs, phase};

    task automatic build_exp();
        logic [3:0] c4;
        logic [2:0] p3;
        exp_q.delete();
        for (int c = 0; c < CS_N; c++) begin
            for (int p = 0; p < PH_N; p++) begin
                c4 = c[3:0];
                p3 = p[2:0];
                exp_q.push_back({c4, p3, salt, c4, p3});
            end
        end
    endtask

    // Drives one sweep from a start pulse until done/err or a cycle budget, recording what the DUT does.
    task automatic run_sweep(input int bp_idx, input int starve_idx, input int start_idx);
        int          cycles = 0;
        int          last_rise = -1;
        int          cur, oi;
        bit          hold;
        logic        prev_ov = 1'b0;
        logic [29:0] snap = '0;
        got_q.delete();
        periods.delete();
        n_ack = 0; viol = 0; bp_seen = 0; starve_seen = 0; load_cycles = 0; ov_cnt = 0;
        start_fired = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_after_start = done;
        err_after_start  = err;
        while (!done && !err && cycles < 2000) begin
            cur   = int'(cs) * PH_N + int'(phase);
            oi    = int'(out_cs) * PH_N + int'(out_phase);
            noise = 1'($urandom_range(0, 1));
            start = 1'b0;
            if (cur == start_idx && busy && !start_fired) begin
                start = 1'b1;
                start_fired = 1'b1;
            end
            in_avail = !(cur == starve_idx && starve_seen < 5);
            if (!in_avail) begin
                starve_seen++;
                if (dc_load) viol++;
            end
            hold = out_valid && (oi == bp_idx) && (bp_seen < 10);
            if (hold) begin
                if (bp_seen == 0) snap = {cs, phase, out_cs, out_phase, out_data};
                else if (snap != {cs, phase, out_cs, out_phase, out_data} || dc_load) viol++;
                bp_seen++;
            end
            out_ready = !hold;
            if (dc_load) load_cycles++;
            if (out_valid) ov_cnt++;
            if (in_ack) n_ack++;
            if (out_valid && out_ready) got_q.push_back({out_cs, out_phase, out_data});
            if (out_valid && !prev_ov) begin
                if (last_rise >= 0) periods.push_back(cycles - last_rise);
                last_rise = cycles;
            end
            prev_ov = out_valid;
            @(negedge clk);
            cycles++;
        end
        start = 1'b0; in_avail = 1'b1; out_ready = 1'b1; noise = 1'b0;
    endtask

    task automatic test_reset();
        int cyc = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({dc_load, ws_load, in_ack, out_valid} !== 4'b0) $display("FAIL reset_ctrl: got %b want 0000", {dc_load, ws_load, in_ack, out_valid});
        else n_pass++;
        n_checks++;
        if ({busy, done, err} !== 3'b0) $display("FAIL reset_status: got %b want 000", {busy, done, err});
        else n_pass++;
        n_checks++;
        if ({cs, phase, out_cs, out_phase} !== 14'b0) $display("FAIL reset_index: got %h want 0", {cs, phase, out_cs, out_phase});
        else n_pass++;
        n_checks++;
        if (out_data !== 16'h0) $display("FAIL reset_data: got %h want 0", out_data);
        else n_pass++;

        ch_lat = 6; in_avail = 1'b1; out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (!(dc_load && cs == 4'd1 && phase == 3'd2) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        n_checks++;
        if (!(dc_load && cs == 4'd1 && phase == 3'd2)) $display("FAIL reach_mid_load: got cs=%0d ph=%0d load=%b want cs=1 ph=2 load=1", cs, phase, dc_load);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({dc_load, ws_load, out_valid, busy} !== 4'b0) $display("FAIL midload_reset_ctrl: got %b want 0000", {dc_load, ws_load, out_valid, busy});
        else n_pass++;
        n_checks++;
        if ({cs, phase} !== 7'b0) $display("FAIL midload_reset_index: got cs=%0d ph=%0d want 0 0", cs, phase);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_full_sweep();
        salt = 9'($urandom);
        ch_lat = $urandom_range(0, 4);
        build_exp();
        run_sweep(-1, -1, -1);
        n_checks++;
        if (got_q.size() !== exp_q.size()) $display("FAIL sweep_count: got %0d want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if ((i < got_q.size() ? got_q[i] : '1) !== exp_q[i]) $display("FAIL sweep_result[%0d]: got %h want %h", i, (i < got_q.size() ? got_q[i] : '1), exp_q[i]);
            else n_pass++;
        end
        n_checks++;
        if ({done, err, busy} !== 3'b100) $display("FAIL sweep_status: got done,err,busy=%b want 100", {done, err, busy});
        else n_pass++;
        n_checks++;
        if (n_ack !== CS_N * PH_N) $display("FAIL sweep_in_ack: got %0d want %0d", n_ack, CS_N * PH_N);
        else n_pass++;
        n_checks++;
        if (periods.size() !== CS_N * PH_N - 1) $display("FAIL period_count: got %0d want %0d", periods.size(), CS_N * PH_N - 1);
        else n_pass++;
        foreach (periods[i]) begin
            n_checks++;
            if (periods[i] !== ch_lat + 4) $display("FAIL slice_period[%0d]: got %0d want %0d", i, periods[i], ch_lat + 4);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        salt = 9'($urandom);
        ch_lat = $urandom_range(0, 4);
        build_exp();
        run_sweep(1, -1, -1);
        n_checks++;
        if (done_after_start !== 1'b0) $display("FAIL start_clears_done: got %b want 0", done_after_start);
        else n_pass++;
        n_checks++;
        if (bp_seen !== 10) $display("FAIL bp_hold_cycles: got %0d want 10", bp_seen);
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL bp_stable: got %0d violations want 0", viol);
        else n_pass++;
        n_checks++;
        if (got_q !== exp_q) $display("FAIL bp_results: got %0d results first %h want %0d first %h", got_q.size(), got_q.size() > 0 ? got_q[0] : '1, exp_q.size(), exp_q[0]);
        else n_pass++;
    endtask

    task automatic test_starve();
        salt = 9'($urandom);
        ch_lat = $urandom_range(0, 4);
        build_exp();
        run_sweep(-1, PH_N, -1);
        n_checks++;
        if (starve_seen !== 5) $display("FAIL starve_cycles: got %0d want 5", starve_seen);
        else n_pass++;
        n_checks++;
        if (viol !== 0) $display("FAIL starve_no_load: got %0d load cycles want 0", viol);
        else n_pass++;
        n_checks++;
        if (got_q !== exp_q) $display("FAIL starve_results: got %0d results want %0d", got_q.size(), exp_q.size());
        else n_pass++;
    endtask

    task automatic test_busy_start();
        salt = 9'($urandom);
        ch_lat = $urandom_range(0, 4);
        build_exp();
        run_sweep(-1, -1, 2);
        n_checks++;
        if (start_fired !== 1'b1) $display("FAIL busy_start_issued: got %b want 1", start_fired);
        else n_pass++;
        n_checks++;
        if (got_q !== exp_q) $display("FAIL busy_start_results: got %0d results want %0d", got_q.size(), exp_q.size());
        else n_pass++;
        n_checks++;
        if (n_ack !== CS_N * PH_N || done !== 1'b1) $display("FAIL busy_start_done: got ack=%0d done=%b want %0d 1", n_ack, done, CS_N * PH_N);
        else n_pass++;
    endtask

    task automatic test_timeout();
        ch_dead = 1'b1;
        run_sweep(-1, -1, -1);
        n_checks++;
        if (load_cycles !== TO) $display("FAIL timeout_load_cycles: got %0d want %0d", load_cycles, TO);
        else n_pass++;
        n_checks++;
        if ({err, done, busy, dc_load} !== 4'b1000) $display("FAIL timeout_status: got err,done,busy,load=%b want 1000", {err, done, busy, dc_load});
        else n_pass++;
        n_checks++;
        if (ov_cnt !== 0 || n_ack !== 0) $display("FAIL timeout_no_output: got out_valid=%0d in_ack=%0d want 0 0", ov_cnt, n_ack);
        else n_pass++;

        ch_dead = 1'b0;
        salt = 9'($urandom);
        ch_lat = $urandom_range(0, 4);
        build_exp();
        run_sweep(-1, -1, -1);
        n_checks++;
        if (err_after_start !== 1'b0) $display("FAIL start_clears_err: got %b want 0", err_after_start);
        else n_pass++;
        n_checks++;
        if (got_q !== exp_q || err !== 1'b0) $display("FAIL restart_results: got %0d results err=%b want %0d err=0", got_q.size(), err, exp_q.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_starve();
        test_busy_start();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end
endmodule
